uart_rx_fifo: RTL and testbench

- Receive buffer that sits directly downstream of the UART receiver.
- Captures each error-free byte presented with the receiver's one-cycle data_valid pulse and stores it in a synchronous FIFO.
- Counts parity and stop-bit error pulses; frames flagged with an error are never written.
- Gives the host a registered pop interface, occupancy level, and a sticky overrun flag.

---
 rtl/uart_rx_fifo.sv | 103 ++++++++++
 tb/tb_uart_rx_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind a UART receiver.
//   Stores error-free bytes in a synchronous FIFO, counts parity/stop-bit
//   error pulses with saturating counters and flags dropped bytes.
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   rx_data, rx_valid   byte from receiver, one-cycle good-frame pulse
//   rx_par_err          one-cycle parity error pulse
//   rx_stp_err          one-cycle stop-bit error pulse
//   rd_en               host pop request
//   clr_err             clears overrun and both error counters
//   rd_data, rd_valid   registered popped byte and its one-cycle strobe
//   empty, full, level  occupancy decodes and occupancy count 0..DEPTH
//   overrun             sticky: a good byte was dropped while full
//   par_err_cnt         saturating parity error count
//   stp_err_cnt         saturating stop-bit error count
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_par_err,
    input  logic                  rx_stp_err,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overrun,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overrun_q, overrun_d;
    logic [CNT_WIDTH-1:0]  par_q, par_d, stp_q, stp_d;
    logic                  good, pop, push;

    assign empty = level_q == '0;
    assign full  = level_q == (ADDR_WIDTH+1)'(DEPTH);

    always_comb begin
        // a frame flagged with any error never reaches the FIFO
        good       = rx_valid && !rx_par_err && !rx_stp_err;
        pop        = rd_en && !empty;
        // a full FIFO still accepts a byte when a pop frees a slot this cycle
        push       = good && (!full || pop);
        wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
        level_d    = (push && !pop) ? level_q + 1'b1 :
                     (pop && !push) ? level_q - 1'b1 : level_q;
        rd_data_d  = pop ? mem_q[rptr_q] : rd_data_q;
        rd_valid_d = pop;
        // set wins over clear so a drop in the clearing cycle is not lost
        overrun_d  = (good && full && !rd_en) || (overrun_q && !clr_err);
        par_d      = clr_err ? CNT_WIDTH'(rx_par_err) :
                     (rx_par_err && par_q != '1) ? par_q + 1'b1 : par_q;
        stp_d      = clr_err ? CNT_WIDTH'(rx_stp_err) :
                     (rx_stp_err && stp_q != '1) ? stp_q + 1'b1 : stp_q;
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wptr_q] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            par_q      <= '0;
            stp_q      <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
            par_q      <= par_d;
            stp_q      <= stp_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign level       = level_q;
    assign overrun     = overrun_q;
    assign par_err_cnt = par_q;
    assign stp_err_cnt = stp_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed vector table plus hand-written sequences for uart_rx_fifo.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0, rx_par_err = 1'b0, rx_stp_err = 1'b0;
    logic       rd_en = 1'b0, clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, empty, full, overrun;
    logic [4:0] level;
    logic [7:0] par_err_cnt, stp_err_cnt;
    int checks = 0;
    int failures = 0;

    uart_rx_fifo dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err), .rd_en(rd_en),
        .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid),
        .empty(empty), .full(full), .level(level), .overrun(overrun),
        .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [7:0] d;
        logic       v, pe, se, rd, clr;
        logic [7:0] e_data;
        logic       e_rv;
        logic [4:0] e_lvl;
        logic       e_ovr;
        logic [7:0] e_pc, e_sc;
    } vec_t;

    vec_t tbl[20];

    task automatic step(input logic r, input logic [7:0] d, input logic v,
                        input logic pe, input logic se, input logic rd, input logic clr);
        rst = r; rx_data = d; rx_valid = v; rx_par_err = pe;
        rx_stp_err = se; rd_en = rd; clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, a, e);
        end
    endtask

    logic [7:0] q[$];
    logic [7:0] ed, dv;
    logic       dp, dr, ep;
    int         sent, cyc;

    initial begin
        //           r  d      v  pe se rd clr  data   rv lvl ovr pc  sc
        tbl[0]  = '{1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 8'hA5, 1, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0};
        tbl[2]  = '{0, 8'h3C, 1, 0, 0, 0, 0, 8'h00, 0, 2, 0, 0, 0};
        tbl[3]  = '{0, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 0, 3, 0, 0, 0};
        tbl[4]  = '{0, 8'h00, 0, 0, 0, 1, 0, 8'hA5, 1, 2, 0, 0, 0};
        tbl[5]  = '{0, 8'h00, 0, 0, 0, 1, 0, 8'h3C, 1, 1, 0, 0, 0};
        tbl[6]  = '{0, 8'h00, 0, 0, 0, 1, 0, 8'hFF, 1, 0, 0, 0, 0};
        tbl[7]  = '{0, 8'h00, 0, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 8'h00, 0, 0, 0, 1, 0, 8'hFF, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 8'h12, 1, 0, 0, 1, 0, 8'hFF, 0, 1, 0, 0, 0};
        tbl[10] = '{0, 8'h00, 0, 0, 0, 1, 0, 8'h12, 1, 0, 0, 0, 0};
        tbl[11] = '{0, 8'h00, 0, 1, 0, 0, 0, 8'h12, 0, 0, 0, 1, 0};
        tbl[12] = '{0, 8'h99, 1, 1, 1, 0, 0, 8'h12, 0, 0, 0, 2, 1};
        tbl[13] = '{0, 8'h00, 0, 0, 1, 0, 0, 8'h12, 0, 0, 0, 2, 2};
        tbl[14] = '{0, 8'h00, 0, 1, 0, 0, 0, 8'h12, 0, 0, 0, 3, 2};
        tbl[15] = '{0, 8'h00, 0, 0, 1, 0, 1, 8'h12, 0, 0, 0, 0, 1};
        tbl[16] = '{0, 8'h44, 1, 1, 0, 0, 0, 8'h12, 0, 0, 0, 1, 1};
        tbl[17] = '{0, 8'h00, 0, 0, 0, 0, 1, 8'h12, 0, 0, 0, 0, 0};
        tbl[18] = '{0, 8'h21, 1, 0, 0, 0, 0, 8'h12, 0, 1, 0, 0, 0};
        tbl[19] = '{1, 8'h22, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0};

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].r, tbl[i].d, tbl[i].v, tbl[i].pe, tbl[i].se, tbl[i].rd, tbl[i].clr);
            chk($sformatf("v%0d_rd_data", i), rd_data, tbl[i].e_data);
            chk($sformatf("v%0d_rd_valid", i), rd_valid, tbl[i].e_rv);
            chk($sformatf("v%0d_level", i), level, tbl[i].e_lvl);
            chk($sformatf("v%0d_empty", i), empty, tbl[i].e_lvl == 0);
            chk($sformatf("v%0d_full", i), full, 0);
            chk($sformatf("v%0d_overrun", i), overrun, tbl[i].e_ovr);
            chk($sformatf("v%0d_par_cnt", i), par_err_cnt, tbl[i].e_pc);
            chk($sformatf("v%0d_stp_cnt", i), stp_err_cnt, tbl[i].e_sc);
        end

        // fill, overrun, set-wins clear, push-while-full-with-pop, drain
        for (int i = 0; i < 16; i++) begin
            step(0, 8'(i), 1, 0, 0, 0, 0);
            chk("fill_level", level, i + 1);
        end
        chk("fill_full", full, 1);
        chk("fill_empty", empty, 0);
        step(0, 8'h55, 1, 0, 0, 0, 0);
        chk("ovr_set", overrun, 1);
        chk("ovr_level", level, 16);
        step(0, 8'h56, 1, 0, 0, 0, 1);
        chk("ovr_set_wins", overrun, 1);
        chk("ovr_set_wins_level", level, 16);
        step(0, 8'h00, 0, 0, 0, 0, 1);
        chk("ovr_clr", overrun, 0);
        chk("ovr_clr_level", level, 16);
        step(0, 8'h77, 1, 0, 0, 1, 0);
        chk("fullpp_rv", rd_valid, 1);
        chk("fullpp_data", rd_data, 8'h00);
        chk("fullpp_level", level, 16);
        chk("fullpp_ovr", overrun, 0);
        for (int i = 1; i < 16; i++) begin
            step(0, 8'h00, 0, 0, 0, 1, 0);
            chk("drain_rv", rd_valid, 1);
            chk("drain_data", rd_data, i);
        end
        step(0, 8'h00, 0, 0, 0, 1, 0);
        chk("drain_last", rd_data, 8'h77);
        chk("drain_level", level, 0);
        chk("drain_empty", empty, 1);
        step(0, 8'h00, 0, 0, 0, 0, 0);
        chk("idle_rv", rd_valid, 0);
        chk("idle_hold", rd_data, 8'h77);

        // pointer wrap with random interleave against a queue model
        sent = 0;
        cyc = 0;
        while ((sent < 40 || q.size() > 0) && cyc < 1000) begin
            dp = sent < 40 && q.size() < 16 && ($urandom_range(0, 2) != 0);
            dr = 1'($urandom_range(0, 1));
            dv = 8'(sent * 37 + 11);
            ep = dr && q.size() > 0;
            ed = 8'h00;
            if (ep) ed = q.pop_front();
            if (dp) begin
                q.push_back(dv);
                sent++;
            end
            step(0, dv, dp, 0, 0, dr, 0);
            chk("wrap_rv", rd_valid, ep);
            if (ep) chk("wrap_data", rd_data, ed);
            chk("wrap_level", level, q.size());
            cyc++;
        end
        chk("wrap_bounded", cyc < 1000, 1);
        chk("wrap_end_level", level, 0);

        // parity counter saturation
        for (int i = 0; i < 300; i++) step(0, 8'h00, 0, 1, 0, 0, 0);
        chk("sat_par", par_err_cnt, 255);
        chk("sat_stp", stp_err_cnt, 0);
        chk("sat_level", level, 0);

        // reset mid-stream with stored bytes and nonzero state
        step(0, 8'hAB, 1, 0, 0, 0, 0);
        step(0, 8'hCD, 1, 0, 1, 0, 0);
        step(0, 8'hEF, 1, 0, 0, 1, 0);
        chk("mid_rv", rd_valid, 1);
        chk("mid_data", rd_data, 8'hAB);
        chk("mid_level", level, 1);
        chk("mid_stp", stp_err_cnt, 1);
        step(1, 8'h11, 1, 1, 1, 1, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_rv", rd_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_par", par_err_cnt, 0);
        chk("rst_stp", stp_err_cnt, 0);
        step(0, 8'h00, 0, 0, 0, 1, 0);
        chk("post_rst_rv", rd_valid, 0);
        chk("post_rst_level", level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
